// File: rtl/order_sequencer.sv
// Order sequencer: steps through the order cache one entry at a time, launches
// the compute engine for each executable opcode and waits for it to finish.
// Reports task completion, illegal opcodes, order overflow and engine timeouts.
module order_sequencer #(
    parameter int MAX_ORDERS     = 512,
    parameter int COUNT_W        = 10,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TIMER_W        = 32
) (
    input  logic               system_clk,
    input  logic               rst_n,
    input  logic               task_start,
    input  logic               abort,
    input  logic [2:0]         order,
    input  logic [7:0]         order_id,
    input  logic               exec_done,
    output logic               pop_order_en,
    output logic               exec_start,
    output logic [2:0]         exec_type,
    output logic               busy,
    output logic               task_done,
    output logic               task_error,
    output logic [1:0]         error_code,
    output logic [COUNT_W-1:0] order_count,
    output logic [7:0]         last_id
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_DECODE,
        S_EXEC,
        S_WAIT_DONE,
        S_FINISH,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_END = 3'd5;

    localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_ORDERS);

    // A zero timeout disables the watchdog; the compare value is then unused.
    localparam bit                 TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST =
        TIMER_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    state_t             state;
    logic [TIMER_W-1:0] timer;

    // Single-process FSM. Every output is registered and set on the transition
    // into the state that owns it, so pulses coincide exactly with their state.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            timer        <= '0;
            pop_order_en <= 1'b0;
            exec_start   <= 1'b0;
            exec_type    <= '0;
            busy         <= 1'b0;
            task_done    <= 1'b0;
            task_error   <= 1'b0;
            error_code   <= '0;
            order_count  <= '0;
            last_id      <= '0;
        end else begin
            pop_order_en <= 1'b0;
            exec_start   <= 1'b0;
            task_done    <= 1'b0;

            if (abort && (state != S_IDLE)) begin
                // Abort beats everything: drop to idle without pulses and leave
                // the error flags and counters as they are.
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (task_start) begin
                            state        <= S_POP;
                            pop_order_en <= 1'b1;
                            busy         <= 1'b1;
                            order_count  <= '0;
                            task_error   <= 1'b0;
                            error_code   <= '0;
                        end
                    end

                    // The cache loads its output register on this edge, so the
                    // opcode is only looked at in the following state.
                    S_POP: begin
                        state <= S_DECODE;
                    end

                    S_DECODE: begin
                        if (order == OP_NOP) begin
                            state        <= S_POP;
                            pop_order_en <= 1'b1;
                        end else if (order == OP_END) begin
                            state     <= S_FINISH;
                            task_done <= 1'b1;
                            busy      <= 1'b0;
                        end else if (order < OP_END) begin
                            state      <= S_EXEC;
                            exec_start <= 1'b1;
                            exec_type  <= order;
                            last_id    <= order_id;
                            if (order_count < MAX_COUNT) begin
                                order_count <= order_count + 1'b1;
                            end
                        end else begin
                            state      <= S_ERROR;
                            task_error <= 1'b1;
                            error_code <= ERR_ILLEGAL;
                            busy       <= 1'b0;
                        end
                    end

                    // The launch pulse is high in this state; the wait timer
                    // starts counting from the first waiting cycle.
                    S_EXEC: begin
                        state <= S_WAIT_DONE;
                        timer <= '0;
                    end

                    // A done arriving on the last allowed cycle still counts.
                    S_WAIT_DONE: begin
                        if (exec_done) begin
                            if (order_count < MAX_COUNT) begin
                                state        <= S_POP;
                                pop_order_en <= 1'b1;
                            end else begin
                                state      <= S_ERROR;
                                task_error <= 1'b1;
                                error_code <= ERR_OVERFLOW;
                                busy       <= 1'b0;
                            end
                        end else if (TIMEOUT_EN && (timer == TIMEOUT_LAST)) begin
                            state      <= S_ERROR;
                            task_error <= 1'b1;
                            error_code <= ERR_TIMEOUT;
                            busy       <= 1'b0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end

                    S_FINISH: begin
                        state <= S_IDLE;
                    end

                    S_ERROR: begin
                        state <= S_IDLE;
                    end

                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_order_sequencer.sv
// Bench for order_sequencer: an order cache model and a compute engine model
// feed the DUT, directed tasks queue the expected launch/done/error events, and
// a monitor consumes that queue whenever the DUT raises one of those outputs.
module tb_order_sequencer;

    localparam int MAX_ORDERS     = 3;
    localparam int COUNT_W        = 10;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int TIMER_W        = 32;

    localparam int K_LAUNCH = 0;
    localparam int K_DONE   = 1;
    localparam int K_ERR    = 2;

    logic               system_clk = 1'b0;
    logic               rst_n      = 1'b0;
    logic               task_start = 1'b0;
    logic               abort      = 1'b0;
    logic [2:0]         order      = 3'd0;
    logic [7:0]         order_id   = 8'd0;
    logic               exec_done;
    logic               pop_order_en;
    logic               exec_start;
    logic [2:0]         exec_type;
    logic               busy;
    logic               task_done;
    logic               task_error;
    logic [1:0]         error_code;
    logic [COUNT_W-1:0] order_count;
    logic [7:0]         last_id;

    logic eng_done   = 1'b0;
    logic stray_done = 1'b0;
    assign exec_done = eng_done | stray_done;

    order_sequencer #(
        .MAX_ORDERS    (MAX_ORDERS),
        .COUNT_W       (COUNT_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMER_W       (TIMER_W)
    ) dut (
        .system_clk  (system_clk),
        .rst_n       (rst_n),
        .task_start  (task_start),
        .abort       (abort),
        .order       (order),
        .order_id    (order_id),
        .exec_done   (exec_done),
        .pop_order_en(pop_order_en),
        .exec_start  (exec_start),
        .exec_type   (exec_type),
        .busy        (busy),
        .task_done   (task_done),
        .task_error  (task_error),
        .error_code  (error_code),
        .order_count (order_count),
        .last_id     (last_id)
    );

    always #5 system_clk = ~system_clk;

    int cyc = 0;
    always @(posedge system_clk) cyc <= cyc + 1;

    typedef struct {
        string      tag;
        int         kind;
        logic [2:0] typ;
        logic [7:0] id;
        int         count;
        logic [1:0] code;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] cache_op [8];
    logic [7:0] cache_id [8];
    int cache_ptr = 0;
    int pop_count = 0;
    int eng_delay = 0;
    logic err_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge system_clk);
        #1;
    endtask

    task automatic put(input int idx, input logic [2:0] op, input logic [7:0] id);
        cache_op[idx] = op;
        cache_id[idx] = id;
    endtask

    task automatic push(input string tag, input int kind, input logic [2:0] typ,
                        input logic [7:0] id, input int count, input logic [1:0] code,
                        input int at);
        ev_t e;
        e.tag = tag; e.kind = kind; e.typ = typ; e.id = id;
        e.count = count; e.code = code; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic start_task(input logic with_abort);
        cache_ptr  = 0;
        task_start = 1'b1;
        abort      = with_abort;
        tick(1);
        task_start = 1'b0;
        abort      = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        check({name, "_busy_drop"}, {31'd0, busy}, 32'd0);
        tick(2);
        check({name, "_events_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_pop"},   {31'd0, pop_order_en}, 32'd0);
        check({name, "_start"}, {31'd0, exec_start},   32'd0);
        check({name, "_type"},  {29'd0, exec_type},    32'd0);
        check({name, "_busy"},  {31'd0, busy},         32'd0);
        check({name, "_done"},  {31'd0, task_done},    32'd0);
        check({name, "_err"},   {31'd0, task_error},   32'd0);
        check({name, "_code"},  {30'd0, error_code},   32'd0);
        check({name, "_count"}, 32'(order_count),      32'd0);
        check({name, "_id"},    {24'd0, last_id},      32'd0);
    endtask

    // Order cache: output register loads on the edge that samples pop_order_en.
    initial begin
        forever begin
            @(posedge system_clk);
            if (rst_n && pop_order_en) begin
                #1;
                order    = cache_op[cache_ptr % 8];
                order_id = cache_id[cache_ptr % 8];
                cache_ptr++;
                pop_count++;
            end
        end
    end

    // Compute engine: done pulse eng_delay cycles after the launch cycle.
    initial begin
        forever begin
            @(posedge system_clk);
            if (rst_n && exec_start && eng_delay > 0) begin
                repeat (eng_delay - 1) @(posedge system_clk);
                #1 eng_done = 1'b1;
                @(posedge system_clk);
                #1 eng_done = 1'b0;
            end
        end
    end

    task automatic see_event(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            check({e.tag, "_kind"}, kind, e.kind);
            if (e.cyc >= 0) check({e.tag, "_cycle"}, cyc, e.cyc);
            case (e.kind)
                K_LAUNCH: begin
                    check({e.tag, "_type"},  {29'd0, exec_type}, {29'd0, e.typ});
                    check({e.tag, "_id"},    {24'd0, last_id},   {24'd0, e.id});
                    check({e.tag, "_count"}, 32'(order_count),   e.count);
                end
                K_DONE: begin
                    check({e.tag, "_count"}, 32'(order_count), e.count);
                    check({e.tag, "_id"},    {24'd0, last_id}, {24'd0, e.id});
                    check({e.tag, "_busy"},  {31'd0, busy},    32'd0);
                end
                default: begin
                    check({e.tag, "_code"}, {30'd0, error_code}, {30'd0, e.code});
                    check({e.tag, "_busy"}, {31'd0, busy},       32'd0);
                end
            endcase
        end
    endtask

    // Monitor: consumes one queued expectation per observed DUT event.
    initial begin
        forever begin
            @(negedge system_clk);
            if (rst_n) begin
                if (exec_start) see_event(K_LAUNCH);
                if (task_done) see_event(K_DONE);
                if (task_error && !err_prev) see_event(K_ERR);
            end
            err_prev = task_error;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int p0;

        repeat (3) @(posedge system_clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // 1: {1,2,5}, done one cycle after each launch.
        put(0, 3'd1, 8'h11); put(1, 3'd2, 8'h22); put(2, 3'd5, 8'h55);
        eng_delay = 1;
        t0 = cyc; p0 = pop_count;
        push("t1_launch1", K_LAUNCH, 3'd1, 8'h11, 1, 2'd0, t0 + 3);
        push("t1_launch2", K_LAUNCH, 3'd2, 8'h22, 2, 2'd0, t0 + 7);
        push("t1_done",    K_DONE,   3'd0, 8'h22, 2, 2'd0, t0 + 11);
        start_task(1'b0);
        check("t1_busy_after_start", {31'd0, busy}, 32'd1);
        check("t1_first_pop", {31'd0, pop_order_en}, 32'd1);
        wait_idle("t1", 40);
        check("t1_pops", pop_count - p0, 32'd3);
        check("t1_count", 32'(order_count), 32'd2);

        // 2: {0,0,3,5}; abort raised together with task_start from idle.
        put(0, 3'd0, 8'h01); put(1, 3'd0, 8'h02); put(2, 3'd3, 8'h33); put(3, 3'd5, 8'h55);
        t0 = cyc; p0 = pop_count;
        push("t2_launch", K_LAUNCH, 3'd3, 8'h33, 1, 2'd0, t0 + 7);
        push("t2_done",   K_DONE,   3'd0, 8'h33, 1, 2'd0, t0 + 11);
        start_task(1'b1);
        check("t2_busy_after_start", {31'd0, busy}, 32'd1);
        wait_idle("t2", 40);
        check("t2_pops", pop_count - p0, 32'd4);

        // 3: {4,6}: illegal opcode after one launch.
        put(0, 3'd4, 8'h44); put(1, 3'd6, 8'h66);
        t0 = cyc;
        push("t3_launch", K_LAUNCH, 3'd4, 8'h44, 1, 2'd0, t0 + 3);
        push("t3_err",    K_ERR,    3'd0, 8'h00, 0, 2'd1, t0 + 7);
        start_task(1'b0);
        wait_idle("t3", 40);
        check("t3_err_sticky", {31'd0, task_error}, 32'd1);
        check("t3_code_sticky", {30'd0, error_code}, 32'd1);

        // 4a: engine never answers -> timeout after 8 waiting cycles.
        put(0, 3'd2, 8'h2A); put(1, 3'd5, 8'h55);
        eng_delay = 0;
        t0 = cyc;
        push("t4a_launch", K_LAUNCH, 3'd2, 8'h2A, 1, 2'd0, t0 + 3);
        push("t4a_err",    K_ERR,    3'd0, 8'h00, 0, 2'd3, t0 + 12);
        start_task(1'b0);
        check("t4a_err_cleared", {31'd0, task_error}, 32'd0);
        wait_idle("t4a", 40);
        check("t4a_code", {30'd0, error_code}, 32'd3);

        // 4b: done on the 8th waiting cycle wins over the timeout.
        put(0, 3'd3, 8'h3B); put(1, 3'd5, 8'h55);
        eng_delay = 8;
        t0 = cyc;
        push("t4b_launch", K_LAUNCH, 3'd3, 8'h3B, 1, 2'd0, t0 + 3);
        push("t4b_done",   K_DONE,   3'd0, 8'h3B, 1, 2'd0, t0 + 14);
        start_task(1'b0);
        wait_idle("t4b", 40);
        check("t4b_no_err", {31'd0, task_error}, 32'd0);

        // 5: four launches against a limit of three -> overflow.
        put(0, 3'd1, 8'h51); put(1, 3'd1, 8'h52); put(2, 3'd1, 8'h53); put(3, 3'd1, 8'h54);
        eng_delay = 1;
        t0 = cyc; p0 = pop_count;
        push("t5_launch1", K_LAUNCH, 3'd1, 8'h51, 1, 2'd0, t0 + 3);
        push("t5_launch2", K_LAUNCH, 3'd1, 8'h52, 2, 2'd0, t0 + 7);
        push("t5_launch3", K_LAUNCH, 3'd1, 8'h53, 3, 2'd0, t0 + 11);
        push("t5_err",     K_ERR,    3'd0, 8'h00, 0, 2'd2, t0 + 13);
        start_task(1'b0);
        wait_idle("t5", 60);
        check("t5_pops", pop_count - p0, 32'd3);
        check("t5_count", 32'(order_count), 32'd3);

        // 6: abort while waiting, then a stray done.
        put(0, 3'd1, 8'h61); put(1, 3'd2, 8'h62); put(2, 3'd5, 8'h55);
        eng_delay = 0;
        t0 = cyc;
        push("t6_launch", K_LAUNCH, 3'd1, 8'h61, 1, 2'd0, t0 + 3);
        start_task(1'b0);
        tick(4);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("t6_busy_after_abort", {31'd0, busy}, 32'd0);
        p0 = pop_count;
        stray_done = 1'b1;
        tick(1);
        stray_done = 1'b0;
        tick(4);
        check("t6_no_pop", pop_count - p0, 32'd0);
        check("t6_busy_idle", {31'd0, busy}, 32'd0);
        check("t6_err_unchanged", {31'd0, task_error}, 32'd0);
        check("t6_count_held", 32'(order_count), 32'd1);
        check("t6_events_left", exp_q.size(), 32'd0);
        exp_q.delete();

        // 6b: a new task restarts counting from zero.
        put(0, 3'd2, 8'h62); put(1, 3'd5, 8'h55);
        eng_delay = 1;
        t0 = cyc;
        push("t6b_launch", K_LAUNCH, 3'd2, 8'h62, 1, 2'd0, t0 + 3);
        push("t6b_done",   K_DONE,   3'd0, 8'h62, 1, 2'd0, t0 + 7);
        start_task(1'b0);
        wait_idle("t6b", 40);

        // 6c: asynchronous reset in the middle of a task.
        put(0, 3'd4, 8'h71); put(1, 3'd1, 8'h72); put(2, 3'd5, 8'h55);
        eng_delay = 0;
        t0 = cyc;
        push("t6c_launch", K_LAUNCH, 3'd4, 8'h71, 1, 2'd0, t0 + 3);
        start_task(1'b0);
        tick(4);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("t6c_busy_idle", {31'd0, busy}, 32'd0);
        check("t6c_events_left", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
